// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the pipelined MIPS core.
//
// Selects the next fetch address and holds the PC register. The next PC comes from one of:
// sequential (PC + STEP), a branch/jump redirect, exception entry, or ERET return. A redirect
// that arrives while the pipeline is stalled goes into a one-deep pending buffer. The buffered
// target is loaded on the first edge with Stall low.
//
// Ports:
//   Clk          in   rising-edge clock
//   Rst          in   synchronous active-high reset
//   Stall        in   hold PC this cycle (hazard unit)
//   Redir        in   branch/jump taken this cycle
//   RedirTarget  in   branch/jump target address
//   ExcReq       in   exception entry request (highest priority after reset)
//   EretReq      in   return-from-exception request
//   Epc          in   ERET return address
//   PC           out  current fetch address (registered)
//   PC4          out  PC + STEP (combinational, wraps)
//   Pending      out  a deferred redirect is buffered
//   AlignErr     out  one-cycle pulse: a misaligned target was replaced by EXC_VEC
//
// Optional feature macro: PC_ALIGN_CHK_EN
//   When defined, any target about to be loaded (RedirTarget, buffered target or Epc) that has
//   bits [1:0] != 0 is not loaded. PC goes to EXC_VEC instead and AlignErr pulses.
//   When undefined, targets load unmodified and AlignErr is tied low.

module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 'h0000_4180,
  parameter int unsigned      STEP      = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Redir,
  input  logic [WIDTH-1:0] RedirTarget,
  input  logic             ExcReq,
  input  logic             EretReq,
  input  logic [WIDTH-1:0] Epc,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic             Pending,
  output logic             AlignErr
);

  typedef enum logic {
    StIdle,
    StHeld
  } state_e;

  state_e           state_q, state_d;
  // Initialiser gives the documented power-up value in simulation; Rst sets it in hardware.
  logic [WIDTH-1:0] pc_q = RESET_VEC;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] pc4;

  // A target load is requested separately from the selection, so the alignment trap (when
  // built) can replace whichever target was chosen.
  logic             load_tgt;
  logic [WIDTH-1:0] tgt;

  assign pc4 = pc_q + WIDTH'(STEP);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    pc_d     = pc_q;
    load_tgt = 1'b0;
    tgt      = pc_q;

    if (ExcReq) begin
      pc_d    = EXC_VEC;
      state_d = StIdle;
    end else if (EretReq) begin
      load_tgt = 1'b1;
      tgt      = Epc;
      state_d  = StIdle;
    end else if (Redir && !Stall) begin
      // A fresh redirect supersedes anything buffered.
      load_tgt = 1'b1;
      tgt      = RedirTarget;
      state_d  = StIdle;
    end else if (Redir) begin
      buf_d   = RedirTarget;
      state_d = StHeld;
    end else if (!Stall && (state_q == StHeld)) begin
      load_tgt = 1'b1;
      tgt      = buf_q;
      state_d  = StIdle;
    end else if (!Stall) begin
      pc_d = pc4;
    end

    if (load_tgt) begin
      pc_d = tgt;
    end

`ifdef PC_ALIGN_CHK_EN
    // EXC_VEC bypasses this path, so it is never checked.
    if (load_tgt && (tgt[1:0] != 2'b00)) begin
      pc_d = EXC_VEC;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_VEC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic align_err_q, align_err_d;

  assign align_err_d = !ExcReq && load_tgt && (tgt[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign AlignErr = align_err_q;
`else
  assign AlignErr = 1'b0;
`endif

  assign PC      = pc_q;
  assign PC4     = pc4;
  assign Pending = (state_q == StHeld);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit.
// A directed walk through the main scenarios is followed by randomized stimulus. Every cycle is
// compared against a behavioural model that keeps the PC as an integer and the pending redirect
// as a queue of at most one entry.

module tb_pc_unit;

  localparam logic [31:0] ResetVec = 32'h0000_3000;
  localparam logic [31:0] ExcVec   = 32'h0000_4180;
  localparam int unsigned Step     = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        Redir;
  logic [31:0] RedirTarget;
  logic        ExcReq;
  logic        EretReq;
  logic [31:0] Epc;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Pending;
  logic        AlignErr;

  pc_unit #(
    .WIDTH    (32),
    .RESET_VEC(ResetVec),
    .EXC_VEC  (ExcVec),
    .STEP     (Step)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Stall      (Stall),
    .Redir      (Redir),
    .RedirTarget(RedirTarget),
    .ExcReq     (ExcReq),
    .EretReq    (EretReq),
    .Epc        (Epc),
    .PC         (PC),
    .PC4        (PC4),
    .Pending    (Pending),
    .AlignErr   (AlignErr)
  );

  always #5 Clk = ~Clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] m_pc = ResetVec;
  logic [31:0] m_buf[$];
  logic        m_ae = 1'b0;

  task automatic m_load(input logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
    if (t % 4 != 0) begin
      m_pc = ExcVec;
      m_ae = 1'b1;
      return;
    end
`endif
    m_pc = t;
  endtask

  task automatic m_step();
    logic [31:0] b;
    m_ae = 1'b0;
    if (Rst) begin
      m_pc = ResetVec;
      m_buf.delete();
    end else if (ExcReq) begin
      m_pc = ExcVec;
      m_buf.delete();
    end else if (EretReq) begin
      m_buf.delete();
      m_load(Epc);
    end else if (Redir && !Stall) begin
      m_buf.delete();
      m_load(RedirTarget);
    end else if (Redir) begin
      m_buf.delete();
      m_buf.push_back(RedirTarget);
    end else if (Stall) begin
      // hold everything
    end else if (m_buf.size() != 0) begin
      b = m_buf.pop_front();
      m_load(b);
    end else begin
      m_pc = m_pc + Step;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs against the model.
  task automatic cyc(input logic rst, input logic stall, input logic redir,
                     input logic [31:0] tgt, input logic exc, input logic eret,
                     input logic [31:0] epc);
    Rst = rst; Stall = stall; Redir = redir; RedirTarget = tgt;
    ExcReq = exc; EretReq = eret; Epc = epc;
    m_step();
    @(posedge Clk);
    #1;
    check_eq("pc", PC, m_pc);
    check_eq("pc4", PC4, m_pc + Step);
    check_eq("pending", {31'b0, Pending}, {31'b0, (m_buf.size() != 0)});
    check_eq("align_err", {31'b0, AlignErr}, {31'b0, m_ae});
  endtask

  task automatic free_run();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redir = 1'b0; RedirTarget = '0;
    ExcReq = 1'b0; EretReq = 1'b0; Epc = '0;
    #1;
    check_eq("init_pc", PC, ResetVec);

    // Reset, then free-run.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("plan_reset_pc", PC, 32'h3000);
    free_run(); check_eq("plan_seq1", PC, 32'h3004);
    free_run(); check_eq("plan_seq2", PC, 32'h3008);
    free_run(); check_eq("plan_seq3", PC, 32'h300C);
    free_run(); check_eq("plan_seq4", PC, 32'h3010);

    // Unstalled redirect.
    cyc(1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    check_eq("plan_redir", PC, 32'h3100);
    free_run(); check_eq("plan_redir_seq", PC, 32'h3104);

    // Redirect during a 3-cycle stall is deferred until the stall clears.
    cyc(1'b0, 1'b1, 1'b1, 32'h3200, 1'b0, 1'b0, 32'h0);
    check_eq("plan_held_pc", PC, 32'h3104);
    check_eq("plan_held_pend", {31'b0, Pending}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    free_run();
    check_eq("plan_deferred", PC, 32'h3200);
    check_eq("plan_deferred_pend", {31'b0, Pending}, 32'd0);

    // Exception while a redirect is pending, then ERET.
    cyc(1'b0, 1'b1, 1'b1, 32'h3300, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("plan_exc", PC, 32'h4180);
    check_eq("plan_exc_pend", {31'b0, Pending}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3024);
    check_eq("plan_eret", PC, 32'h3024);
    // ExcReq beats EretReq.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3024);
    check_eq("plan_exc_over_eret", PC, 32'h4180);

    // Wrap-around at the top of the address space.
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    check_eq("plan_pc4_wrap", PC4, 32'h0);
    free_run();
    check_eq("plan_wrap", PC, 32'h0);

    // Reset while HELD.
    cyc(1'b0, 1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h3500, 1'b0, 1'b0, 32'h0);
    check_eq("plan_rst_held_pc", PC, 32'h3000);
    check_eq("plan_rst_held_pend", {31'b0, Pending}, 32'd0);

    // Misaligned redirect.
    cyc(1'b0, 1'b0, 1'b1, 32'h3102, 1'b0, 1'b0, 32'h0);
`ifdef PC_ALIGN_CHK_EN
    check_eq("plan_misalign_pc", PC, 32'h4180);
    check_eq("plan_misalign_ae", {31'b0, AlignErr}, 32'd1);
    free_run();
    check_eq("plan_misalign_ae_drop", {31'b0, AlignErr}, 32'd0);
`else
    check_eq("plan_misalign_pc", PC, 32'h3102);
    check_eq("plan_misalign_ae", {31'b0, AlignErr}, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      logic [31:0] e;
      t = $urandom();
      e = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) e[1:0] = 2'b00;
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0),
          t,
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 24) == 0),
          e);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core; successor to the fixed 32-bit stall-only PC register.
- Owns next-PC selection (sequential, branch/jump redirect, exception entry, ERET return) and the PC register itself.
- Holds a one-deep pending-redirect buffer, so a redirect raised during a stall is applied once the stall clears.
- Feeds the IF stage and instruction memory.

Parameters:
WIDTH, 32, PC width in bits (min 16)
RESET_VEC, 'h0000_3000, PC value after reset
EXC_VEC, 'h0000_4180, exception handler entry address
STEP, 4, sequential increment in bytes

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  synchronous reset, active-high
Stall  input  1  hold PC this cycle (hazard unit)
Redir  input  1  branch/jump taken this cycle
RedirTarget  input  WIDTH  branch/jump target
ExcReq  input  1  exception entry request
EretReq  input  1  return-from-exception request
Epc  input  WIDTH  return address for ERET
PC  output  WIDTH  current fetch address (registered)
PC4  output  WIDTH  PC + STEP (combinational)
Pending  output  1  a deferred redirect is buffered
AlignErr  output  1  misaligned target trap taken (see Optional Feature)

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high (Clk, Rst).
  - Rst high at a rising edge: PC <= RESET_VEC, pending buffer cleared, Pending=0, AlignErr=0.
  - Rst overrides every other input, including mid-stall and with a redirect pending.
- Initial simulation value: PC = RESET_VEC.
- Arithmetic: PC4 = PC + STEP, truncated to WIDTH (wraps modulo 2^WIDTH; all-ones region + STEP wraps to low addresses with no flag).
- State machine, two states:
  - IDLE (Pending=0)
  - HELD (Pending=1; pending buffer holds the target)
- Next-state priority per rising edge, highest first:
  1. Rst: as above.
  2. ExcReq: PC <= EXC_VEC regardless of Stall; pending cleared; state -> IDLE.
  3. EretReq: PC <= Epc regardless of Stall; pending cleared; state -> IDLE.
  4. Redir with Stall=0: PC <= RedirTarget; pending cleared; state -> IDLE. A new redirect overrides a buffered one.
  5. Redir with Stall=1: PC held; RedirTarget captured into the buffer (overwrites any older entry); state -> HELD.
  6. Stall=0 in HELD (no Redir): PC <= buffer; state -> IDLE.
  7. Stall=1 with no Redir: PC held; buffer and state unchanged.
  8. Otherwise: PC <= PC4.
- Simultaneous ExcReq and EretReq: ExcReq wins.
- Latency: every redirect takes effect on PC one edge after it is accepted; a deferred redirect takes effect on the first edge with Stall=0.
- Pending is registered and equals (state == HELD).

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - Any target about to be loaded (RedirTarget, buffer, Epc) with bits [1:0] != 0 is not loaded. Instead PC <= EXC_VEC, and AlignErr pulses high for exactly one cycle, registered with that PC update.
  - EXC_VEC itself is never checked.
- Undefined:
  - Targets are loaded unmodified.
  - AlignErr is tied 0.
  - No extra logic is generated.

Test Plan:
- Reset, then 3 free-running cycles -> PC = 'h3000, 'h3004, 'h3008, 'h300C; Pending=0.
- PC='h3010; Redir=1, RedirTarget='h3100, Stall=0 -> next PC='h3100, then 'h3104.
- PC='h3020; Stall=1 for 3 cycles, Redir pulsed in cycle 1 with target 'h3200 -> PC stays 'h3020, Pending=1 from the next edge; first edge with Stall=0 gives PC='h3200, Pending=0.
- Stall=1, Pending=1 (buffer 'h3200); ExcReq=1 -> PC='h4180, Pending=0. Then EretReq=1, Epc='h3024 -> PC='h3024.
- PC='hFFFF_FFFC, free-run -> PC='h0000_0000 next edge. Rst asserted while HELD -> PC='h3000, Pending=0.
- With PC_ALIGN_CHK_EN: Redir, target 'h3102 -> PC='h4180, AlignErr=1 for one cycle. Without the macro: PC='h3102, AlignErr=0.
